// File: rtl/sym_vn_lut_load_ctrl_pkg.sv
// Shared constants and state encoding for the symmetric VN LUT load sequencer.
//   QUAN_SIZE  : LUT entry width (quantised message bits)
//   LUT_ADDR_W : LUT address width
//   LUT_DEPTH  : entries per table
//   TAG_W      : table tag width (iteration index)
//   CNT_W      : beat counter width (one bit wider than the address)
package sym_vn_lut_load_ctrl_pkg;

    localparam int unsigned QUAN_SIZE  = 4;
    localparam int unsigned LUT_ADDR_W = 7;
    localparam int unsigned LUT_DEPTH  = 128;
    localparam int unsigned TAG_W      = 5;
    localparam int unsigned CNT_W      = LUT_ADDR_W + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2
    } state_e;

endpackage

// File: rtl/sym_vn_lut_load_ctrl.sv
// Load sequencer for the symmetric variable-node LUT. Streams a new table into
// the LUT write port and arbitrates the shared read/write port with the decoder.
// Ports:
//   write_clk_i, rst_i          : clock, synchronous active-high reset
//   load_start_i, load_tag_i    : start a table load (IDLE only), tag captured
//   load_abort_i                : cancel an in-progress load
//   src_valid_i, src_data_i     : table stream in address order
//   src_ready_o                 : beat accepted this cycle
//   lut_we_o, lut_write_addr_o,
//   lut_in_o                    : registered LUT write port
//   dec_rd_req_i, dec_rd_gnt_o  : decoder request / grant of the shared port
//   lut_busy_o                  : load in progress or write pending
//   table_valid_o, cur_tag_o    : complete table present and its tag
//   load_done_o                 : one-cycle pulse when a table completes
module sym_vn_lut_load_ctrl
    import sym_vn_lut_load_ctrl_pkg::*;
(
    input  logic                  write_clk_i,
    input  logic                  rst_i,
    input  logic                  load_start_i,
    input  logic [TAG_W-1:0]      load_tag_i,
    input  logic                  load_abort_i,
    input  logic                  src_valid_i,
    input  logic [QUAN_SIZE-1:0]  src_data_i,
    output logic                  src_ready_o,
    output logic                  lut_we_o,
    output logic [LUT_ADDR_W-1:0] lut_write_addr_o,
    output logic [QUAN_SIZE-1:0]  lut_in_o,
    input  logic                  dec_rd_req_i,
    output logic                  dec_rd_gnt_o,
    output logic                  lut_busy_o,
    output logic                  table_valid_o,
    output logic [TAG_W-1:0]      cur_tag_o,
    output logic                  load_done_o
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]        pend_tag_q, pend_tag_d;
    logic [TAG_W-1:0]        cur_tag_q, cur_tag_d;
    logic                    lut_we_q, lut_we_d;
    logic [LUT_ADDR_W-1:0]   addr_q, addr_d;
    logic [QUAN_SIZE-1:0]    data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    table_valid_q, table_valid_d;
    logic                    load_done_q, load_done_d;
    logic                    beat;
    logic                    last_beat;

    // Abort masks ready so a beat offered in the abort cycle is never taken.
    assign src_ready_o = (state_q == StLoad) & ~load_abort_i;
    assign beat        = src_valid_i & src_ready_o;
    assign last_beat   = (cnt_q == CNT_W'(LUT_DEPTH - 1));

    // State register
    always_ff @(posedge write_clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (load_abort_i) begin
                    state_d = StIdle;
                end else if (beat && last_beat) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d         = cnt_q;
        pend_tag_d    = pend_tag_q;
        cur_tag_d     = cur_tag_q;
        lut_we_d      = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        table_valid_d = table_valid_q;
        load_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    pend_tag_d    = load_tag_i;
                    table_valid_d = 1'b0;
                    cnt_d         = '0;
                end
            end
            StLoad: begin
                if (beat) begin
                    lut_we_d = 1'b1;
                    addr_d   = cnt_q[LUT_ADDR_W-1:0];
                    data_d   = src_data_i;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            StFlush: begin
                if (!load_abort_i) begin
                    table_valid_d = 1'b1;
                    cur_tag_d     = pend_tag_q;
                    load_done_d   = 1'b1;
                end
            end
            default: ;
        endcase
        // Registered so the decoder grant path stays a simple AND of flops.
        busy_d = (state_d != StIdle) | lut_we_d;
    end

    always_ff @(posedge write_clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            pend_tag_q    <= '0;
            cur_tag_q     <= '0;
            lut_we_q      <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            table_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            pend_tag_q    <= pend_tag_d;
            cur_tag_q     <= cur_tag_d;
            lut_we_q      <= lut_we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            table_valid_q <= table_valid_d;
            load_done_q   <= load_done_d;
        end
    end

    assign lut_we_o         = lut_we_q;
    assign lut_write_addr_o = addr_q;
    assign lut_in_o         = data_q;
    assign lut_busy_o       = busy_q;
    assign table_valid_o    = table_valid_q;
    assign cur_tag_o        = cur_tag_q;
    assign load_done_o      = load_done_q;
    assign dec_rd_gnt_o     = dec_rd_req_i & ~busy_q & table_valid_q;

endmodule

// File: tb/tb_sym_vn_lut_load_ctrl.sv
module tb_sym_vn_lut_load_ctrl;
    import sym_vn_lut_load_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load_start;
    logic [TAG_W-1:0]      load_tag;
    logic                  load_abort;
    logic                  src_valid;
    logic [QUAN_SIZE-1:0]  src_data;
    logic                  src_ready;
    logic                  lut_we;
    logic [LUT_ADDR_W-1:0] lut_write_addr;
    logic [QUAN_SIZE-1:0]  lut_in;
    logic                  dec_rd_req;
    logic                  dec_rd_gnt;
    logic                  lut_busy;
    logic                  table_valid;
    logic [TAG_W-1:0]      cur_tag;
    logic                  load_done;

    always #5 clk = ~clk;

    sym_vn_lut_load_ctrl u_dut (
        .write_clk_i      (clk),
        .rst_i            (rst),
        .load_start_i     (load_start),
        .load_tag_i       (load_tag),
        .load_abort_i     (load_abort),
        .src_valid_i      (src_valid),
        .src_data_i       (src_data),
        .src_ready_o      (src_ready),
        .lut_we_o         (lut_we),
        .lut_write_addr_o (lut_write_addr),
        .lut_in_o         (lut_in),
        .dec_rd_req_i     (dec_rd_req),
        .dec_rd_gnt_o     (dec_rd_gnt),
        .lut_busy_o       (lut_busy),
        .table_valid_o    (table_valid),
        .cur_tag_o        (cur_tag),
        .load_done_o      (load_done)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    logic [QUAN_SIZE-1:0] lut_mem [LUT_DEPTH];
    logic [QUAN_SIZE-1:0] ref_tbl [LUT_DEPTH];
    // Reference model: table presence and tag as seen by the decoder side.
    bit  m_tv;
    int  m_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every LUT write must match the next expected beat.
    always @(negedge clk) begin : mon
        wr_t w;
        if (lut_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                         lut_write_addr, lut_in, $time);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(lut_write_addr), w.addr);
                check("wr_data", 32'(lut_in), w.data);
            end
            lut_mem[lut_write_addr] = lut_in;
            check("gnt_during_we", 32'(dec_rd_gnt), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(src_ready), 0);
        check({tag, "_we"}, 32'(lut_we), 0);
        check({tag, "_addr"}, 32'(lut_write_addr), 0);
        check({tag, "_data"}, 32'(lut_in), 0);
        check({tag, "_busy"}, 32'(lut_busy), 0);
        check({tag, "_tv"}, 32'(table_valid), 0);
        check({tag, "_tag"}, 32'(cur_tag), 0);
        check({tag, "_done"}, 32'(load_done), 0);
    endtask

    // One load attempt. abort_at / restart_at / rst_at give the accepted-beat
    // count at which that event is injected (-1 = never).
    task automatic do_load(input int tag, input int gap_period, input int abort_at,
                           input int restart_at, input int rst_at, input bit fixed_data,
                           input bit rand_req);
        int beats = 0;
        int cyc   = 0;
        int errs  = 0;
        logic [QUAN_SIZE-1:0] d;
        bit v;
        load_start = 1'b1;
        load_tag   = TAG_W'(tag);
        @(negedge clk);
        check("busy_at_start", 32'(lut_busy), 0);
        check("gnt_at_start", 32'(dec_rd_gnt), 32'(dec_rd_req & m_tv));
        step();
        load_start = 1'b0;
        while (beats < LUT_DEPTH) begin
            v = (gap_period == 0) || ((cyc % gap_period) != gap_period - 1);
            d = fixed_data ? beats[QUAN_SIZE-1:0] : QUAN_SIZE'($urandom);
            src_valid  = v;
            src_data   = d;
            load_abort = (beats == abort_at);
            rst        = (beats == rst_at);
            if (beats == restart_at) begin
                load_start = 1'b1;
                load_tag   = TAG_W'(tag ^ 31);
            end
            if (rand_req) dec_rd_req = 1'($urandom);
            @(negedge clk);
            if (rst) begin
                step();
                rst       = 1'b0;
                src_valid = 1'b0;
                @(negedge clk);
                check_reset_vals("rst");
                m_tv  = 1'b0;
                m_tag = 0;
                step();
                return;
            end
            if (load_abort) begin
                check("ready_in_abort", 32'(src_ready), 0);
                step();
                load_abort = 1'b0;
                src_valid  = 1'b0;
                @(negedge clk);
                check("we_after_abort", 32'(lut_we), 0);
                check("busy_after_abort", 32'(lut_busy), 0);
                check("done_after_abort", 32'(load_done), 0);
                check("tv_after_abort", 32'(table_valid), 0);
                check("tag_after_abort", 32'(cur_tag), 32'(m_tag));
                m_tv = 1'b0;
                step();
                return;
            end
            check("ready_load", 32'(src_ready), 1);
            check("busy_load", 32'(lut_busy), 1);
            check("gnt_load", 32'(dec_rd_gnt), 0);
            check("done_load", 32'(load_done), 0);
            if (v) begin
                exp_q.push_back('{addr: beats, data: int'(d)});
                ref_tbl[beats] = d;
                beats++;
            end
            cyc++;
            step();
            load_start = 1'b0;
        end
        // Flush cycle: last write on the port, nothing more accepted.
        src_valid = 1'b1;
        src_data  = QUAN_SIZE'($urandom);
        @(negedge clk);
        check("ready_flush", 32'(src_ready), 0);
        check("busy_flush", 32'(lut_busy), 1);
        check("done_flush", 32'(load_done), 0);
        check("tv_flush", 32'(table_valid), 0);
        step();
        src_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(load_done), 1);
        check("tv_done", 32'(table_valid), 1);
        check("tag_done", 32'(cur_tag), 32'(tag));
        check("busy_done", 32'(lut_busy), 0);
        check("gnt_done", 32'(dec_rd_gnt), 32'(dec_rd_req));
        check("pending_writes", 32'(exp_q.size()), 0);
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (lut_mem[i] !== ref_tbl[i]) errs++;
        end
        check("readback", 32'(errs), 0);
        m_tv  = 1'b1;
        m_tag = tag;
        step();
        @(negedge clk);
        check("done_one_cycle", 32'(load_done), 0);
        step();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_tag   = '0;
        load_abort = 1'b0;
        src_valid  = 1'b0;
        src_data   = '0;
        dec_rd_req = 1'b1;
        m_tv       = 1'b0;
        m_tag      = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        check("gnt_reset", 32'(dec_rd_gnt), 0);
        step();

        // Continuous stream, data = addr[3:0]
        do_load(3, 0, -1, -1, -1, 1'b1, 1'b0);
        // Source gaps every third cycle, random decoder requests
        do_load(9, 3, -1, -1, -1, 1'b0, 1'b1);
        dec_rd_req = 1'b1;

        // Abort ignored in IDLE
        load_abort = 1'b1;
        @(negedge clk);
        check("gnt_idle", 32'(dec_rd_gnt), 1);
        step();
        load_abort = 1'b0;
        @(negedge clk);
        check("tv_idle_abort", 32'(table_valid), 1);
        check("busy_idle_abort", 32'(lut_busy), 0);
        step();

        // Abort after 50 beats, then a clean reload
        do_load(12, 0, 50, -1, -1, 1'b0, 1'b0);
        do_load(7, 0, -1, -1, -1, 1'b0, 1'b0);
        // Start during LOAD is ignored
        do_load(21, 0, -1, 20, -1, 1'b0, 1'b0);
        // Reset mid-load, grant stays low until reloaded
        do_load(4, 0, -1, -1, 90, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("gnt_after_rst", 32'(dec_rd_gnt), 0);
            step();
        end
        do_load(30, 4, -1, -1, -1, 1'b0, 1'b1);

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sym_vn_lut_load_ctrl.md
# sym_vn_lut_load_ctrl

Sequencer for the symmetric variable-node LUT (128 x 4-bit distributed-RAM table, one write/read port plus one read-only port). Streams a new table into the LUT before a decoding iteration, drives its write strobe/address/data, and arbitrates the shared read/write port between the loader and the decoder's read requests. Instantiated once per partial-VNU next to the LUT, fed by the iteration-table source.

## Interface
- QUAN_SIZE, 4, LUT entry width (quantised message bits)
- LUT_ADDR_W, 7, LUT address width
- LUT_DEPTH, 128, entries per table (2^LUT_ADDR_W)
- TAG_W, 5, width of the table tag (iteration index)

- write_clk  in  1  single clock for the block and the LUT write port
- rst  in  1  synchronous, active-high reset
- load_start  in  1  request to load a new table; honoured only in IDLE
- load_tag  in  TAG_W  tag of the table to load; captured with load_start
- load_abort  in  1  cancel an in-progress load
- src_valid  in  1  table stream beat valid
- src_data  in  QUAN_SIZE  table entry, in address order 0..LUT_DEPTH-1
- src_ready  out  1  block accepts a beat this cycle
- lut_we  out  1  LUT write enable
- lut_write_addr  out  LUT_ADDR_W  LUT write address
- lut_in  out  QUAN_SIZE  LUT write data
- dec_rd_req  in  1  decoder wants the shared read/write port this cycle
- dec_rd_gnt  out  1  shared port read is valid this cycle
- lut_busy  out  1  load in progress; shared port unavailable to decoder
- table_valid  out  1  LUT holds a complete table
- cur_tag  out  TAG_W  tag of the table in the LUT (valid when table_valid)
- load_done  out  1  one-cycle pulse: table complete

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE: src_ready=0. load_start -> capture load_tag into a pending register, clear table_valid, beat counter=0, go LOAD.
- LOAD: src_ready=1. Each accepted beat (src_valid&src_ready) registers lut_we=1, lut_write_addr=counter, lut_in=src_data for the next cycle; counter increments. Accepting beat LUT_DEPTH-1 -> FLUSH. No beat -> lut_we=0 next cycle; addr/data hold.
- FLUSH: src_ready=0; the final write (addr LUT_DEPTH-1) is on the port. Next cycle: IDLE, table_valid=1, cur_tag=pending tag, load_done=1 for one cycle.
- load_abort in LOAD or FLUSH: next cycle IDLE, lut_we=0, table_valid stays 0, no load_done, cur_tag unchanged. A beat offered in the abort cycle is not accepted (src_ready forced 0). load_abort in IDLE: ignored.
- load_start in LOAD/FLUSH: ignored. load_start and load_abort together in IDLE: start wins.
- lut_busy = (state != IDLE) | lut_we, registered.
- dec_rd_gnt = dec_rd_req & ~lut_busy & table_valid (combinational). Granted reads never coincide with lut_we=1.
- Counter is LUT_ADDR_W+1 bits wide; no wrap past LUT_DEPTH-1 within a load.

## Timing
- Reset values: state IDLE, src_ready 0, lut_we 0, lut_write_addr 0, lut_in 0, lut_busy 0, table_valid 0, cur_tag 0, load_done 0, counter 0.
- load_start at cycle t -> LOAD and src_ready=1, lut_busy=1 at t+1.
- Beat accepted at t -> write presented at t+1, committed on the t+1/t+2 edge.
- Back-to-back stream: load_start at t, beats t+1..t+128, FLUSH at t+129 (last write), load_done=1, table_valid=1, lut_busy=0 at t+130. Minimum load = 130 cycles after load_start.
- dec_rd_req in the load_start cycle is still granted (busy rises next cycle).
- rst mid-load: next cycle all outputs at reset values; partial table is discarded (table_valid 0).

## Structure
- Shared package: QUAN_SIZE, LUT_ADDR_W, LUT_DEPTH, TAG_W, state encoding (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2).
- Single module, no sub-module; write-port output register inside. The LUT itself is instantiated by the parent, not here.

## Test plan
- Reset, then load_start tag=3 with continuous src_valid, data=addr[3:0] -> 128 writes addr 0..127, load_done at start+130, table_valid=1, cur_tag=3; LUT readback matches.
- Source gaps: src_valid low every third cycle -> no write in gap cycles, addresses contiguous, load_done after 128th beat +2 cycles.
- dec_rd_req held high throughout load -> dec_rd_gnt=0 from start+1 until load_done cycle, 1 from that cycle; never with lut_we=1.
- load_abort after 50 beats -> lut_we=0 next cycle, no load_done, table_valid=0, cur_tag keeps old value; new load_start tag=7 completes normally.
- load_start during LOAD (beat 20) -> ignored, pending tag unchanged, still exactly 128 writes.
- rst at beat 90 -> all outputs at reset values next cycle; dec_rd_gnt=0 until a full reload.
